// File: rtl/output_demux_pkg.sv
// Shared constants and state encoding for output_demux.
package output_demux_pkg;

  localparam int         NUM_QUEUES_MAX  = 8;
  localparam logic [7:0] OD_IOQ_CTRL     = 8'hFF;
  localparam int         OD_DST_PORT_POS = 16;

  // ST_DROP is only reachable when OUTPUT_DEMUX_DROP_EN is defined.
  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small fall-through FIFO: the head entry is visible on dout_o while !empty_o.
// nearly_full_o asserts with one free slot left, so a writer that checks it
// before each write never overflows.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             nearly_full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             cnt_q;
  logic                      full, do_wr, do_rd;

  assign full          = (cnt_q == CW'(DEPTH));
  assign empty_o       = (cnt_q == '0);
  assign nearly_full_o = (cnt_q >= CW'(DEPTH - 1));
  assign dout_o        = mem_q[rd_ptr_q];
  assign do_rd         = rd_en_i && !empty_o;
  // A write at full depth is accepted when the head leaves in the same cycle.
  assign do_wr         = wr_en_i && (!full || do_rd);

  // Storage array; contents need no reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr && !do_rd)      cnt_q <= cnt_q + 1'b1;
      else if (!do_wr && do_rd) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/output_demux.sv
// Packet demux: routes each packet from the input FIFO to the queues named by
// its IOQ header mask, writing all selected queues in the same cycle.
// Optional feature macro OUTPUT_DEMUX_DROP_EN: unroutable packets are
// discarded and counted on drop_cnt; without it they go to DEFAULT_QUEUE.
module output_demux
  import output_demux_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int                    NUM_QUEUES    = 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL      = OD_IOQ_CTRL,
  parameter int                    DST_PORT_POS  = OD_DST_PORT_POS,
  parameter int                    DEFAULT_QUEUE = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [CTRL_WIDTH-1:0]            in_ctrl,
  input  logic                             in_wr,
  output logic                             in_rdy,
  output logic [NUM_QUEUES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_QUEUES*CTRL_WIDTH-1:0] out_ctrl,
  output logic [NUM_QUEUES-1:0]            out_wr,
  input  logic [NUM_QUEUES-1:0]            out_rdy
`ifdef OUTPUT_DEMUX_DROP_EN
  ,
  output logic [15:0]                      drop_cnt
`endif
);

  localparam int FW = DATA_WIDTH + CTRL_WIDTH;

  logic [FW-1:0]         fifo_dout;
  logic                  fifo_empty, fifo_nf, fifo_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  fallthrough_small_fifo #(.WIDTH(FW), .MAX_DEPTH_BITS(2)) u_in_fifo (
    .clk          (clk),
    .reset        (reset),
    .din_i        ({in_ctrl, in_data}),
    .wr_en_i      (in_wr),
    .rd_en_i      (fifo_rd),
    .dout_o       (fifo_dout),
    .nearly_full_o(fifo_nf),
    .empty_o      (fifo_empty)
  );

  assign in_rdy = ~fifo_nf;
  assign {head_ctrl, head_data} = fifo_dout;

  state_e                state_q, state_d;
  logic [NUM_QUEUES-1:0] dst_mask_q, dst_mask_d, dst_eff, hdr_mask;
  logic                  seen_data_q, seen_data_d;
  logic                  xfer, hdr_ok, head_is_data, eop, hdr_go, pkt_go;
  logic [NUM_QUEUES-1:0] out_wr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;

  // Header decode; mask bits above NUM_QUEUES fall outside the slice.
  assign hdr_mask     = head_data[DST_PORT_POS +: NUM_QUEUES];
  assign hdr_ok       = (head_ctrl == IOQ_CTRL) && (|hdr_mask);
  assign head_is_data = (head_ctrl == '0);
  assign eop          = seen_data_q && !head_is_data;
  // A word moves only when every selected queue can take it (no partial multicast).
  assign hdr_go       = !fifo_empty && (&(out_rdy | ~hdr_mask));
  assign pkt_go       = !fifo_empty && (&(out_rdy | ~dst_mask_q));

`ifdef OUTPUT_DEMUX_DROP_EN
  logic        drop_inc;
  logic [15:0] drop_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  localparam logic [NUM_QUEUES-1:0] DEF_MASK = NUM_QUEUES'(1) << DEFAULT_QUEUE;
  logic def_go;
  assign def_go = !fifo_empty && (&(out_rdy | ~DEF_MASK));
`endif

  // Next-state: destination selection, transfer decision and FIFO pop.
  always_comb begin
    state_d     = state_q;
    dst_mask_d  = dst_mask_q;
    seen_data_d = seen_data_q;
    dst_eff     = dst_mask_q;
    xfer        = 1'b0;
    fifo_rd     = 1'b0;
`ifdef OUTPUT_DEMUX_DROP_EN
    drop_inc    = 1'b0;
`endif
    case (state_q)
      ST_HEAD: begin
        if (hdr_ok) begin
          dst_eff = hdr_mask;
          xfer    = hdr_go;
          if (hdr_go) begin
            dst_mask_d  = hdr_mask;
            seen_data_d = 1'b0;
            state_d     = ST_PKT;
          end
        end else begin
`ifdef OUTPUT_DEMUX_DROP_EN
          // The bad head word is the first word of the discarded packet.
          fifo_rd = !fifo_empty;
          if (!fifo_empty) begin
            seen_data_d = head_is_data;
            state_d     = ST_DROP;
          end
`else
          dst_eff = DEF_MASK;
          xfer    = def_go;
          if (def_go) begin
            dst_mask_d  = DEF_MASK;
            seen_data_d = head_is_data;
            state_d     = ST_PKT;
          end
`endif
        end
      end
      ST_PKT: begin
        xfer = pkt_go;
        if (pkt_go) begin
          if (head_is_data) seen_data_d = 1'b1;
          if (eop)          state_d     = ST_HEAD;
        end
      end
`ifdef OUTPUT_DEMUX_DROP_EN
      ST_DROP: begin
        fifo_rd = !fifo_empty;
        if (!fifo_empty) begin
          if (head_is_data) seen_data_d = 1'b1;
          if (eop) begin
            state_d  = ST_HEAD;
            drop_inc = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_HEAD;
    endcase
    if (xfer) fifo_rd = 1'b1;
  end

  // FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HEAD;
      dst_mask_q  <= '0;
      seen_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dst_mask_q  <= dst_mask_d;
      seen_data_q <= seen_data_d;
    end
  end

  // Registered output stage; the word is held between transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr_q   <= '0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      out_wr_q <= xfer ? dst_eff : '0;
      if (xfer) begin
        out_data_q <= head_data;
        out_ctrl_q <= head_ctrl;
      end
    end
  end

`ifdef OUTPUT_DEMUX_DROP_EN
  // Saturating count of discarded packets.
  always_ff @(posedge clk) begin
    if (reset)                                drop_cnt_q <= '0;
    else if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end
`endif

  assign out_wr   = out_wr_q;
  assign out_data = {NUM_QUEUES{out_data_q}};
  assign out_ctrl = {NUM_QUEUES{out_ctrl_q}};

endmodule

// File: tb/tb_output_demux.sv
// Directed bench for output_demux: vector table plus hand sequences for
// stall, backpressure and mid-packet reset. Honors OUTPUT_DEMUX_DROP_EN.
module tb_output_demux;

  localparam int DW = 64, CW = 8, NQ = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [DW-1:0]    in_data;
  logic [CW-1:0]    in_ctrl;
  logic             in_wr;
  logic             in_rdy;
  logic [NQ*DW-1:0] out_data;
  logic [NQ*CW-1:0] out_ctrl;
  logic [NQ-1:0]    out_wr;
  logic [NQ-1:0]    out_rdy;
`ifdef OUTPUT_DEMUX_DROP_EN
  logic [15:0]      drop_cnt;
  localparam logic [7:0] ZM = 8'h00;
`else
  localparam logic [7:0] ZM = 8'h01;
`endif

  always #5 clk = ~clk;

  output_demux #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy)
`ifdef OUTPUT_DEMUX_DROP_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  typedef struct { logic [7:0] ctrl; logic [63:0] data; logic [7:0] exp_wr; } vec_t;
  typedef struct { int cyc; logic [7:0] wr; logic [63:0] data; logic [7:0] ctrl; bit repl; } ev_t;

  ev_t  log_q[$];
  ev_t  exp_q[$];
  vec_t tbl[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output write, checking that all slices carry the same word.
  always @(negedge clk) begin
    if (!reset && out_wr != '0) begin
      ev_t e;
      e.cyc = cyc; e.wr = out_wr; e.data = out_data[DW-1:0]; e.ctrl = out_ctrl[CW-1:0]; e.repl = 1'b1;
      for (int q = 1; q < NQ; q++)
        if (out_data[q*DW +: DW] !== e.data || out_ctrl[q*CW +: CW] !== e.ctrl) e.repl = 1'b0;
      log_q.push_back(e);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [63:0] d, output int at);
    int w = 0;
    while (!in_rdy && w < 40) begin tick(); w++; end
    if (!in_rdy) begin
      n_vec++; n_err++;
      $display("FAIL in_rdy wait: got %b expected 1 within 40 cycles", in_rdy);
    end
    in_wr = 1'b1; in_ctrl = c; in_data = d; at = cyc;
    tick();
    in_wr = 1'b0;
  endtask

  task automatic check_log(input string tag, input bit use_cyc);
    chk($sformatf("%s count", tag), 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s[%0d] out_wr", tag, i), 64'(log_q[i].wr), 64'(exp_q[i].wr));
      chk($sformatf("%s[%0d] data", tag, i), log_q[i].data, exp_q[i].data);
      chk($sformatf("%s[%0d] ctrl", tag, i), 64'(log_q[i].ctrl), 64'(exp_q[i].ctrl));
      chk($sformatf("%s[%0d] repl", tag, i), 64'(log_q[i].repl), 64'd1);
      if (use_cyc) chk($sformatf("%s[%0d] cycle", tag, i), 64'(log_q[i].cyc), 64'(exp_q[i].cyc));
    end
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int at, c0;
    logic [63:0] w2 [6];

    // unicast q2, packet with extra header word to q1, back-to-back to q2,
    // zero mask, non-IOQ ctrl, multicast q7+q0
    tbl.push_back('{8'hFF, 64'h0000_0000_0004_0000, 8'h04});
    tbl.push_back('{8'h00, 64'h1111_1111_1111_1111, 8'h04});
    tbl.push_back('{8'h00, 64'h2222_2222_2222_2222, 8'h04});
    tbl.push_back('{8'h00, 64'h3333_3333_3333_3333, 8'h04});
    tbl.push_back('{8'h10, 64'h4444_4444_4444_4444, 8'h04});
    tbl.push_back('{8'hFF, 64'h0000_00AA_0002_0000, 8'h02});
    tbl.push_back('{8'h40, 64'h5555_5555_5555_5555, 8'h02});
    tbl.push_back('{8'h00, 64'h6666_6666_6666_6666, 8'h02});
    tbl.push_back('{8'h00, 64'h7777_7777_7777_7777, 8'h02});
    tbl.push_back('{8'h20, 64'h8888_8888_8888_8888, 8'h02});
    tbl.push_back('{8'hFF, 64'h0000_0000_0004_0000, 8'h04});
    tbl.push_back('{8'h00, 64'h9999_9999_9999_9999, 8'h04});
    tbl.push_back('{8'h01, 64'hAAAA_AAAA_AAAA_AAAA, 8'h04});
    tbl.push_back('{8'hFF, 64'hDEAD_0000_0000_BEEF, ZM});
    tbl.push_back('{8'h00, 64'hBBBB_BBBB_BBBB_BBBB, ZM});
    tbl.push_back('{8'h00, 64'hCCCC_CCCC_CCCC_CCCC, ZM});
    tbl.push_back('{8'h80, 64'hDDDD_DDDD_DDDD_DDDD, ZM});
    tbl.push_back('{8'h01, 64'h0000_0000_0002_0000, ZM});
    tbl.push_back('{8'h00, 64'hEEEE_EEEE_EEEE_EEEE, ZM});
    tbl.push_back('{8'h08, 64'hFFFF_0000_1234_5678, ZM});
    tbl.push_back('{8'hFF, 64'h0000_0000_0081_0000, 8'h81});
    tbl.push_back('{8'h00, 64'h0123_4567_89AB_CDEF, 8'h81});
    tbl.push_back('{8'h04, 64'hFEDC_BA98_7654_3210, 8'h81});

    reset = 1'b1; in_wr = 1'b0; in_ctrl = '0; in_data = '0; out_rdy = '1;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset out_wr", 64'(out_wr), 64'd0);
    chk("reset out_data", out_data[DW-1:0], 64'd0);
    chk("reset out_ctrl", 64'(out_ctrl[CW-1:0]), 64'd0);
    chk("reset in_rdy", 64'(in_rdy), 64'd1);
`ifdef OUTPUT_DEMUX_DROP_EN
    chk("reset drop_cnt", 64'(drop_cnt), 64'd0);
`endif

    // Continuous stream with all queues ready: every word leaves 2 cycles after its write.
    log_q.delete();
    foreach (tbl[i]) begin
      send(tbl[i].ctrl, tbl[i].data, at);
      if (tbl[i].exp_wr != 8'h00) exp_q.push_back('{at + 2, tbl[i].exp_wr, tbl[i].data, tbl[i].ctrl, 1'b1});
    end
    repeat (6) tick();
    check_log("tbl", 1'b1);
`ifdef OUTPUT_DEMUX_DROP_EN
    chk("drop_cnt after table", 64'(drop_cnt), 64'd2);
`endif

    // Multicast 0x81 with queue 7 not ready for 3 cycles mid-packet.
    w2[0] = 64'h0000_0000_0081_0000;
    for (int i = 1; i < 6; i++) w2[i] = {8{8'hA0 + 8'(i)}};
    c0 = cyc;
    for (int i = 0; i < 6; i++)
      exp_q.push_back('{c0 + ((i == 0) ? 2 : i + 5), 8'h81, w2[i], (i == 0) ? 8'hFF : (i == 5) ? 8'h02 : 8'h00, 1'b1});
    fork
      begin
        for (int i = 0; i < 6; i++) send((i == 0) ? 8'hFF : (i == 5) ? 8'h02 : 8'h00, w2[i], at);
      end
      begin
        repeat (2) tick();
        out_rdy = 8'h7F;
        repeat (3) tick();
        out_rdy = 8'hFF;
      end
    join
    repeat (8) tick();
    check_log("stall", 1'b1);

    // Backpressure: nothing drains, FIFO fills to nearly-full.
    out_rdy = 8'h00;
    for (int i = 0; i < 6; i++) begin
      w2[i] = (i == 0) ? 64'h0000_0000_0010_0000 : {8{8'hB0 + 8'(i)}};
      exp_q.push_back('{0, 8'h10, w2[i], (i == 0) ? 8'hFF : (i == 5) ? 8'h30 : 8'h00, 1'b1});
    end
    send(8'hFF, w2[0], at);
    send(8'h00, w2[1], at);
    chk("bp in_rdy at 2", 64'(in_rdy), 64'd1);
    send(8'h00, w2[2], at);
    chk("bp in_rdy at 3", 64'(in_rdy), 64'd0);
    repeat (3) tick();
    chk("bp no writes", 64'(log_q.size()), 64'd0);
    chk("bp in_rdy held", 64'(in_rdy), 64'd0);
    out_rdy = 8'hFF;
    send(8'h00, w2[3], at);
    send(8'h00, w2[4], at);
    send(8'h30, w2[5], at);
    repeat (8) tick();
    check_log("bp", 1'b0);

    // Reset mid-packet with words stuck in the FIFO.
    send(8'hFF, 64'h0000_0000_0002_0000, at);
    send(8'h00, 64'hC0C0_C0C0_C0C0_C0C0, at);
    out_rdy = 8'hFD;
    send(8'h00, 64'hC1C1_C1C1_C1C1_C1C1, at);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid reset out_wr", 64'(out_wr), 64'd0);
    chk("mid reset in_rdy", 64'(in_rdy), 64'd1);
    log_q.delete();
    exp_q.delete();
    out_rdy = 8'hFF;
    send(8'hFF, 64'h0000_0000_0008_0000, at);
    exp_q.push_back('{at + 2, 8'h08, 64'h0000_0000_0008_0000, 8'hFF, 1'b1});
    send(8'h00, 64'hC2C2_C2C2_C2C2_C2C2, at);
    exp_q.push_back('{at + 2, 8'h08, 64'hC2C2_C2C2_C2C2_C2C2, 8'h00, 1'b1});
    send(8'h03, 64'hC3C3_C3C3_C3C3_C3C3, at);
    exp_q.push_back('{at + 2, 8'h08, 64'hC3C3_C3C3_C3C3_C3C3, 8'h03, 1'b1});
    repeat (6) tick();
    check_log("post reset", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
